// File: rtl/nibble_bus_target.sv
// Target end of the 4-bit nibble serial bus. It decodes a 16-bit address and
// 8-bit data frame, turns it into a req/ack local register access, and drives
// read data back onto the shared nibble lines.
module nibble_bus_target #(
  parameter int SYNC_STAGES = 2,
  parameter int LCL_TIMEOUT = 255
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  inout  wire  [3:0]  coe_conduit_serialData,
  input  logic        coe_conduit_readNotWrite,
  input  logic        coe_conduit_chipSelect,
  input  logic        coe_conduit_serialClock,
  output logic        coe_conduit_irq,
  output logic        lcl_req,
  output logic        lcl_write,
  output logic [15:0] lcl_address,
  output logic [7:0]  lcl_writedata,
  input  logic [7:0]  lcl_readdata,
  input  logic        lcl_ack,
  input  logic        irq_in,
  output logic        err_pulse
);

  // A single flop is not a synchronizer, so the depth is clamped to 2.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int TW = (LCL_TIMEOUT < 2) ? 1 : $clog2(LCL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_DONE, S_WDATA, S_WCOMMIT, S_RFETCH, S_RDRIVE, S_DONE
  } state_t;

  // Synchronizer chains and edge-detect history
  logic [SS-1:0] cs_sync_q, cs_sync_d;
  logic [SS-1:0] rnw_sync_q, rnw_sync_d;
  logic [SS-1:0] sclk_sync_q, sclk_sync_d;
  logic [3:0]    dat_sync_q [SS];
  logic [3:0]    dat_sync_d [SS];
  logic          sclk_prev_q, sclk_prev_d;
  logic          cs_prev_q, cs_prev_d;

  // Transaction state
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          write_q, write_d;
  logic          req_q, req_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    shift_q, shift_d;
  logic          nib_lo_q, nib_lo_d;
  logic          err_q, err_d;
  logic          irq_q, irq_d;
  logic          req_done;

  logic          cs_s, rnw_s, sclk_s;
  logic [3:0]    dat_s;
  logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic          oe;
  logic [3:0]    out_nib;

  assign cs_s      = cs_sync_q[SS-1];
  assign rnw_s     = rnw_sync_q[SS-1];
  assign sclk_s    = sclk_sync_q[SS-1];
  assign dat_s     = dat_sync_q[SS-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Shift every conduit input through its synchronizer chain
  always_comb begin
    cs_sync_d     = {cs_sync_q[SS-2:0], coe_conduit_chipSelect};
    rnw_sync_d    = {rnw_sync_q[SS-2:0], coe_conduit_readNotWrite};
    sclk_sync_d   = {sclk_sync_q[SS-2:0], coe_conduit_serialClock};
    dat_sync_d[0] = coe_conduit_serialData;
    for (int i = 1; i < SS; i++) begin
      dat_sync_d[i] = dat_sync_q[i-1];
    end
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    irq_d       = irq_in;
  end

  // Frame decoder plus local request engine (ack / timeout tracking)
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    req_d      = req_q;
    tmr_d      = tmr_q;
    rdata_d    = rdata_q;
    rd_valid_d = rd_valid_q;
    shift_d    = shift_q;
    nib_lo_d   = nib_lo_q;
    err_d      = 1'b0;
    req_done   = 1'b0;

    // An outstanding request lives on independently of the frame, so an
    // aborted transaction still waits for its ack (or timeout).
    if (req_q) begin
      if (lcl_ack) begin
        req_d      = 1'b0;
        req_done   = 1'b1;
        rd_valid_d = 1'b1;
        rdata_d    = lcl_readdata;
      end else if (tmr_q == TW'(LCL_TIMEOUT - 1)) begin
        req_d      = 1'b0;
        req_done   = 1'b1;
        rd_valid_d = 1'b1;
        rdata_d    = 8'h00;
        err_d      = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    if (cs_fall && (state_q != S_IDLE)) begin
      // Frame ended; anything short of DONE is an abort.
      state_d  = S_IDLE;
      cnt_d    = 3'd0;
      nib_lo_d = 1'b0;
      if (state_q != S_DONE) err_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_rise) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            case (cnt_q[1:0])
              2'd0:    addr_d[15:12] = dat_s;
              2'd1:    addr_d[11:8]  = dat_s;
              2'd2:    addr_d[7:4]   = dat_s;
              default: addr_d[3:0]   = dat_s;
            endcase
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd3) state_d = S_ADDR_DONE;
          end
        end
        S_ADDR_DONE: begin
          if (rnw_s) begin
            // Fetch early so the data is ready for the turnaround edge.
            state_d    = S_RFETCH;
            req_d      = 1'b1;
            write_d    = 1'b0;
            tmr_d      = '0;
            rd_valid_d = 1'b0;
          end else if (sclk_rise) begin
            wdata_d[7:4] = dat_s;
            cnt_d        = cnt_q + 3'd1;
            state_d      = S_WDATA;
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            wdata_d[3:0] = dat_s;
            cnt_d        = cnt_q + 3'd1;
            state_d      = S_WCOMMIT;
            req_d        = 1'b1;
            write_d      = 1'b1;
            tmr_d        = '0;
            rd_valid_d   = 1'b0;
          end
        end
        S_WCOMMIT: begin
          if (req_done) state_d = S_DONE;
        end
        S_RFETCH: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 3'd1;
          end else if (sclk_fall && (cnt_q == 3'd5)) begin
            // Late data is replaced by zeros; a later ack is discarded.
            state_d  = S_RDRIVE;
            nib_lo_d = 1'b0;
            if (rd_valid_d) begin
              shift_d = rdata_d;
            end else begin
              shift_d = 8'h00;
              err_d   = 1'b1;
            end
          end
        end
        S_RDRIVE: begin
          if (sclk_rise && (cnt_q != 3'd7)) begin
            cnt_d = cnt_q + 3'd1;
          end else if (sclk_fall) begin
            if (cnt_q == 3'd6)      nib_lo_d = 1'b1;
            else if (cnt_q == 3'd7) state_d  = S_DONE;
          end
        end
        default: ; // S_DONE: surplus edges are ignored until chipSelect falls
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge csi_clk or negedge rsi_reset) begin
    if (!rsi_reset) begin
      cs_sync_q   <= '0;
      rnw_sync_q  <= '0;
      sclk_sync_q <= '0;
      for (int i = 0; i < SS; i++) dat_sync_q[i] <= 4'h0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      write_q     <= 1'b0;
      req_q       <= 1'b0;
      tmr_q       <= '0;
      rdata_q     <= 8'h00;
      rd_valid_q  <= 1'b0;
      shift_q     <= 8'h00;
      nib_lo_q    <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      rnw_sync_q  <= rnw_sync_d;
      sclk_sync_q <= sclk_sync_d;
      for (int i = 0; i < SS; i++) dat_sync_q[i] <= dat_sync_d[i];
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      req_q       <= req_d;
      tmr_q       <= tmr_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      shift_q     <= shift_d;
      nib_lo_q    <= nib_lo_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  // Drive only while the master is known to be listening; the reset term
  // releases the bus the instant reset asserts.
  assign oe      = rsi_reset && (state_q == S_RDRIVE) && cs_s && rnw_s;
  assign out_nib = nib_lo_q ? shift_q[3:0] : shift_q[7:4];
  assign coe_conduit_serialData = oe ? out_nib : 4'bzzzz;

  assign coe_conduit_irq = irq_q;
  assign lcl_req         = req_q;
  assign lcl_write       = write_q;
  assign lcl_address     = addr_q;
  assign lcl_writedata   = wdata_q;
  assign err_pulse       = err_q;

endmodule
